// File: rtl/decoder_stage_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : decoder_stage_pipe
//  Purpose  : MIPS ID stage with integrated 2R1W register file, MEM/WB
//             operand bypass, one-cycle load-use interlock and ID/EX register.
//  Revision : 1.0  initial release
// ============================================================================
module decoder_stage_pipe #(
    parameter int AWIDTH    = 5,
    parameter int DWIDTH    = 32,
    parameter int IWIDTH    = 32,
    parameter int IMM_WIDTH = 16
) (
    input  logic              dp_clk,
    input  logic              dp_rst,
    input  logic              dp_i_ce,
    input  logic [IWIDTH-1:0] dp_i_instr,
    input  logic              dp_i_flush,
    input  logic              dp_i_wb_wr,
    input  logic [AWIDTH-1:0] dp_i_wb_addr,
    input  logic [DWIDTH-1:0] dp_i_wb_data,
    input  logic              dp_i_fwd_en,
    input  logic [AWIDTH-1:0] dp_i_fwd_addr,
    input  logic [DWIDTH-1:0] dp_i_fwd_data,
    output logic              dp_o_stall,
    output logic              dp_o_ce,
    output logic [5:0]        dp_o_opcode,
    output logic [5:0]        dp_o_funct,
    output logic [4:0]        dp_o_shamt,
    output logic [DWIDTH-1:0] dp_o_data_rs,
    output logic [DWIDTH-1:0] dp_o_data_rt,
    output logic [DWIDTH-1:0] dp_o_imm,
    output logic [AWIDTH-1:0] dp_o_dest,
    output logic              dp_o_reg_wr,
    output logic              dp_o_mem_rd
);

    localparam int         c_NREGS     = 2 ** AWIDTH;
    localparam logic [5:0] c_OP_RTYPE  = 6'h00;
    localparam logic [5:0] c_OP_ADDI   = 6'h08;
    localparam logic [5:0] c_OP_ADDIU  = 6'h09;
    localparam logic [5:0] c_OP_SLTI   = 6'h0A;
    localparam logic [5:0] c_OP_SLTIU  = 6'h0B;
    localparam logic [5:0] c_OP_ANDI   = 6'h0C;
    localparam logic [5:0] c_OP_ORI    = 6'h0D;
    localparam logic [5:0] c_OP_XORI   = 6'h0E;
    localparam logic [5:0] c_OP_LUI    = 6'h0F;
    localparam logic [5:0] c_OP_LW     = 6'h23;

    // ---------------- instruction fields ----------------
    logic [5:0]           w_opcode;
    logic [5:0]           w_funct;
    logic [4:0]           w_shamt;
    logic [AWIDTH-1:0]    w_rs;
    logic [AWIDTH-1:0]    w_rt;
    logic [AWIDTH-1:0]    w_rd;
    logic [IMM_WIDTH-1:0] w_imm_raw;

    assign w_opcode  = dp_i_instr[31:26];
    assign w_funct   = dp_i_instr[5:0];
    assign w_shamt   = dp_i_instr[10:6];
    assign w_rs      = dp_i_instr[25:21];
    assign w_rt      = dp_i_instr[20:16];
    assign w_rd      = dp_i_instr[15:11];
    assign w_imm_raw = dp_i_instr[IMM_WIDTH-1:0];

    // ---------------- register file ----------------
    logic [DWIDTH-1:0] regfile_q [c_NREGS];
    logic [DWIDTH-1:0] regfile_d [c_NREGS];

    always_comb begin
        regfile_d = regfile_q;
        if (dp_i_wb_wr && (dp_i_wb_addr != '0)) begin
            regfile_d[dp_i_wb_addr] = dp_i_wb_data;
        end
    end

    always_ff @(posedge dp_clk) begin
        if (dp_rst) begin
            regfile_q <= '{default: '0};
        end else begin
            regfile_q <= regfile_d;
        end
    end

    // MEM result is younger than the WB result, so it wins.
    function automatic logic [DWIDTH-1:0] f_resolve(
        input logic [AWIDTH-1:0] addr,
        input logic [DWIDTH-1:0] rf_data,
        input logic              fwd_en,
        input logic [AWIDTH-1:0] fwd_addr,
        input logic [DWIDTH-1:0] fwd_data,
        input logic              wb_wr,
        input logic [AWIDTH-1:0] wb_addr,
        input logic [DWIDTH-1:0] wb_data
    );
        logic [DWIDTH-1:0] v;
        if (addr == '0)                         v = '0;
        else if (fwd_en && (fwd_addr == addr))  v = fwd_data;
        else if (wb_wr && (wb_addr == addr))    v = wb_data;
        else                                    v = rf_data;
        return v;
    endfunction

    logic [DWIDTH-1:0] w_data_rs;
    logic [DWIDTH-1:0] w_data_rt;

    assign w_data_rs = f_resolve(w_rs, regfile_q[w_rs], dp_i_fwd_en, dp_i_fwd_addr,
                                 dp_i_fwd_data, dp_i_wb_wr, dp_i_wb_addr, dp_i_wb_data);
    assign w_data_rt = f_resolve(w_rt, regfile_q[w_rt], dp_i_fwd_en, dp_i_fwd_addr,
                                 dp_i_fwd_data, dp_i_wb_wr, dp_i_wb_addr, dp_i_wb_data);

    // ---------------- decode ----------------
    logic              w_zext;
    logic              w_writes;
    logic [DWIDTH-1:0] w_imm;
    logic [AWIDTH-1:0] w_dest;

    always_comb begin
        w_zext   = 1'b0;
        w_writes = 1'b0;
        case (w_opcode)
            c_OP_ANDI, c_OP_ORI, c_OP_XORI: begin
                w_zext   = 1'b1;
                w_writes = 1'b1;
            end
            c_OP_RTYPE, c_OP_ADDI, c_OP_ADDIU, c_OP_SLTI, c_OP_SLTIU,
            c_OP_LUI, c_OP_LW: begin
                w_writes = 1'b1;
            end
            default: begin
                w_writes = 1'b0;
            end
        endcase
    end

    assign w_imm  = w_zext ? DWIDTH'(w_imm_raw) : DWIDTH'($signed(w_imm_raw));
    assign w_dest = (w_opcode == c_OP_RTYPE) ? w_rd : w_rt;

    // ---------------- ID/EX register ----------------
    logic              ce_q,      ce_d;
    logic [5:0]        opcode_q,  opcode_d;
    logic [5:0]        funct_q,   funct_d;
    logic [4:0]        shamt_q,   shamt_d;
    logic [DWIDTH-1:0] data_rs_q, data_rs_d;
    logic [DWIDTH-1:0] data_rt_q, data_rt_d;
    logic [DWIDTH-1:0] imm_q,     imm_d;
    logic [AWIDTH-1:0] dest_q,    dest_d;
    logic              reg_wr_q,  reg_wr_d;
    logic              mem_rd_q,  mem_rd_d;

    logic w_hz;
    logic w_issue;

    // A load in EX whose result is needed now forces one bubble.
    assign w_hz = dp_i_ce & ce_q & mem_rd_q & (dest_q != '0) &
                  ((dest_q == w_rs) | (dest_q == w_rt));
    assign w_issue    = dp_i_ce & ~dp_i_flush & ~w_hz;
    assign dp_o_stall = w_hz & ~dp_i_flush;

    always_comb begin
        opcode_d  = opcode_q;
        funct_d   = funct_q;
        shamt_d   = shamt_q;
        data_rs_d = data_rs_q;
        data_rt_d = data_rt_q;
        imm_d     = imm_q;
        dest_d    = dest_q;
        ce_d      = w_issue;
        reg_wr_d  = w_issue & w_writes;
        mem_rd_d  = w_issue & (w_opcode == c_OP_LW);
        if (w_issue) begin
            opcode_d  = w_opcode;
            funct_d   = w_funct;
            shamt_d   = w_shamt;
            data_rs_d = w_data_rs;
            data_rt_d = w_data_rt;
            imm_d     = w_imm;
            dest_d    = w_dest;
        end
    end

    always_ff @(posedge dp_clk) begin
        if (dp_rst) begin
            ce_q      <= 1'b0;
            opcode_q  <= '0;
            funct_q   <= '0;
            shamt_q   <= '0;
            data_rs_q <= '0;
            data_rt_q <= '0;
            imm_q     <= '0;
            dest_q    <= '0;
            reg_wr_q  <= 1'b0;
            mem_rd_q  <= 1'b0;
        end else begin
            ce_q      <= ce_d;
            opcode_q  <= opcode_d;
            funct_q   <= funct_d;
            shamt_q   <= shamt_d;
            data_rs_q <= data_rs_d;
            data_rt_q <= data_rt_d;
            imm_q     <= imm_d;
            dest_q    <= dest_d;
            reg_wr_q  <= reg_wr_d;
            mem_rd_q  <= mem_rd_d;
        end
    end

    assign dp_o_ce      = ce_q;
    assign dp_o_opcode  = opcode_q;
    assign dp_o_funct   = funct_q;
    assign dp_o_shamt   = shamt_q;
    assign dp_o_data_rs = data_rs_q;
    assign dp_o_data_rt = data_rt_q;
    assign dp_o_imm     = imm_q;
    assign dp_o_dest    = dest_q;
    assign dp_o_reg_wr  = reg_wr_q;
    assign dp_o_mem_rd  = mem_rd_q;

endmodule
`default_nettype wire

// File: tb/tb_decoder_stage_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_decoder_stage_pipe
//  Purpose  : Directed vector table plus reset-during-stall sequence.
//  Revision : 1.0  initial release
// ============================================================================
module tb_decoder_stage_pipe;

    logic        clk;
    logic        rst;
    logic        i_ce;
    logic [31:0] i_instr;
    logic        i_flush;
    logic        i_wb_wr;
    logic [4:0]  i_wb_addr;
    logic [31:0] i_wb_data;
    logic        i_fwd_en;
    logic [4:0]  i_fwd_addr;
    logic [31:0] i_fwd_data;
    logic        o_stall;
    logic        o_ce;
    logic [5:0]  o_opcode;
    logic [5:0]  o_funct;
    logic [4:0]  o_shamt;
    logic [31:0] o_data_rs;
    logic [31:0] o_data_rt;
    logic [31:0] o_imm;
    logic [4:0]  o_dest;
    logic        o_reg_wr;
    logic        o_mem_rd;

    int n_checks = 0;
    int n_errors = 0;

    decoder_stage_pipe dut (
        .dp_clk       (clk),
        .dp_rst       (rst),
        .dp_i_ce      (i_ce),
        .dp_i_instr   (i_instr),
        .dp_i_flush   (i_flush),
        .dp_i_wb_wr   (i_wb_wr),
        .dp_i_wb_addr (i_wb_addr),
        .dp_i_wb_data (i_wb_data),
        .dp_i_fwd_en  (i_fwd_en),
        .dp_i_fwd_addr(i_fwd_addr),
        .dp_i_fwd_data(i_fwd_data),
        .dp_o_stall   (o_stall),
        .dp_o_ce      (o_ce),
        .dp_o_opcode  (o_opcode),
        .dp_o_funct   (o_funct),
        .dp_o_shamt   (o_shamt),
        .dp_o_data_rs (o_data_rs),
        .dp_o_data_rt (o_data_rt),
        .dp_o_imm     (o_imm),
        .dp_o_dest    (o_dest),
        .dp_o_reg_wr  (o_reg_wr),
        .dp_o_mem_rd  (o_mem_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        ce;
        logic [31:0] instr;
        logic        flush;
        logic        wb_wr;
        logic [4:0]  wb_addr;
        logic [31:0] wb_data;
        logic        fwd_en;
        logic [4:0]  fwd_addr;
        logic [31:0] fwd_data;
        logic        x_stall;
        logic        x_ce;
        logic        x_reg_wr;
        logic        x_mem_rd;
        logic [31:0] x_rs;
        logic [31:0] x_rt;
        logic [31:0] x_imm;
        logic [4:0]  x_dest;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        input logic ce, input logic [31:0] instr, input logic flush,
        input logic wb_wr, input logic [4:0] wb_addr, input logic [31:0] wb_data,
        input logic fwd_en, input logic [4:0] fwd_addr, input logic [31:0] fwd_data,
        input logic x_stall, input logic x_ce, input logic x_reg_wr, input logic x_mem_rd,
        input logic [31:0] x_rs, input logic [31:0] x_rt, input logic [31:0] x_imm,
        input logic [4:0] x_dest);
        vec_t v;
        v.ce = ce; v.instr = instr; v.flush = flush;
        v.wb_wr = wb_wr; v.wb_addr = wb_addr; v.wb_data = wb_data;
        v.fwd_en = fwd_en; v.fwd_addr = fwd_addr; v.fwd_data = fwd_data;
        v.x_stall = x_stall; v.x_ce = x_ce; v.x_reg_wr = x_reg_wr; v.x_mem_rd = x_mem_rd;
        v.x_rs = x_rs; v.x_rt = x_rt; v.x_imm = x_imm; v.x_dest = x_dest;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        i_ce       = v.ce;
        i_instr    = v.instr;
        i_flush    = v.flush;
        i_wb_wr    = v.wb_wr;
        i_wb_addr  = v.wb_addr;
        i_wb_data  = v.wb_data;
        i_fwd_en   = v.fwd_en;
        i_fwd_addr = v.fwd_addr;
        i_fwd_data = v.fwd_data;
    endtask

    // Called just after a rising edge; returns just after the next one.
    task automatic apply(input vec_t v, input string tag);
        logic [31:0] ins;
        drive(v);
        #1;
        chk({tag, ".stall"}, 32'(o_stall), 32'(v.x_stall));
        @(posedge clk);
        #1;
        ins = v.instr;
        chk({tag, ".ce"},     32'(o_ce),     32'(v.x_ce));
        chk({tag, ".reg_wr"}, 32'(o_reg_wr), 32'(v.x_reg_wr));
        chk({tag, ".mem_rd"}, 32'(o_mem_rd), 32'(v.x_mem_rd));
        if (v.x_ce) begin
            chk({tag, ".opcode"}, 32'(o_opcode), 32'(ins[31:26]));
            chk({tag, ".funct"},  32'(o_funct),  32'(ins[5:0]));
            chk({tag, ".shamt"},  32'(o_shamt),  32'(ins[10:6]));
            chk({tag, ".rs"},     o_data_rs,     v.x_rs);
            chk({tag, ".rt"},     o_data_rt,     v.x_rt);
            chk({tag, ".imm"},    o_imm,         v.x_imm);
            chk({tag, ".dest"},   32'(o_dest),   32'(v.x_dest));
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".ce"},     32'(o_ce),     32'h0);
        chk({tag, ".reg_wr"}, 32'(o_reg_wr), 32'h0);
        chk({tag, ".mem_rd"}, 32'(o_mem_rd), 32'h0);
        chk({tag, ".opcode"}, 32'(o_opcode), 32'h0);
        chk({tag, ".funct"},  32'(o_funct),  32'h0);
        chk({tag, ".shamt"},  32'(o_shamt),  32'h0);
        chk({tag, ".rs"},     o_data_rs,     32'h0);
        chk({tag, ".rt"},     o_data_rt,     32'h0);
        chk({tag, ".imm"},    o_imm,         32'h0);
        chk({tag, ".dest"},   32'(o_dest),   32'h0);
        chk({tag, ".stall"},  32'(o_stall),  32'h0);
    endtask

    initial begin
        // ce instr flush | wb_wr addr data | fwd_en addr data | stall ce rw mr | rs rt imm dest
        vecs.push_back(mk(0, 32'h0,        0, 1, 1, 32'h5,        0, 0, 32'h0,  0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 32'h0,        0, 1, 2, 32'h7,        0, 0, 32'h0,  0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 32'h00221820, 0, 0, 0, 32'h0,        0, 0, 32'h0,  0, 1, 1, 0, 32'h5, 32'h7, 32'h1820, 3));
        vecs.push_back(mk(1, 32'h00802825, 0, 1, 4, 32'hAABBCCDD, 0, 0, 32'h0,  0, 1, 1, 0, 32'hAABBCCDD, 0, 32'h2825, 5));
        vecs.push_back(mk(0, 32'h0,        0, 1, 0, 32'hFFFFFFFF, 0, 0, 32'h0,  0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 32'h00802825, 0, 0, 0, 32'h0,        0, 0, 32'h0,  0, 1, 1, 0, 32'hAABBCCDD, 0, 32'h2825, 5));
        vecs.push_back(mk(1, 32'h00221820, 0, 1, 1, 32'h22,       1, 1, 32'h11, 0, 1, 1, 0, 32'h11, 32'h7, 32'h1820, 3));
        vecs.push_back(mk(1, 32'h00221820, 0, 0, 0, 32'h0,        0, 0, 32'h0,  0, 1, 1, 0, 32'h22, 32'h7, 32'h1820, 3));
        vecs.push_back(mk(1, 32'h8C260000, 0, 0, 0, 32'h0,        0, 0, 32'h0,  0, 1, 1, 1, 32'h22, 0, 0, 6));
        vecs.push_back(mk(1, 32'h00C23820, 0, 0, 0, 32'h0,        0, 0, 32'h0,  1, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 32'h00C23820, 0, 1, 6, 32'h66,       0, 0, 32'h0,  0, 1, 1, 0, 32'h66, 32'h7, 32'h3820, 7));
        vecs.push_back(mk(1, 32'h20088000, 0, 0, 0, 32'h0,        0, 0, 32'h0,  0, 1, 1, 0, 0, 0, 32'hFFFF8000, 8));
        vecs.push_back(mk(1, 32'h30098000, 0, 0, 0, 32'h0,        0, 0, 32'h0,  0, 1, 1, 0, 0, 0, 32'h00008000, 9));
        vecs.push_back(mk(1, 32'hAC220004, 0, 0, 0, 32'h0,        0, 0, 32'h0,  0, 1, 0, 0, 32'h22, 32'h7, 32'h4, 2));
        vecs.push_back(mk(1, 32'h3C0AFFFF, 0, 0, 0, 32'h0,        0, 0, 32'h0,  0, 1, 1, 0, 0, 0, 32'hFFFFFFFF, 10));
        vecs.push_back(mk(1, 32'h382BFFFF, 0, 0, 0, 32'h0,        0, 0, 32'h0,  0, 1, 1, 0, 32'h22, 0, 32'h0000FFFF, 11));
        vecs.push_back(mk(1, 32'h000260C0, 0, 0, 0, 32'h0,        0, 0, 32'h0,  0, 1, 1, 0, 0, 32'h7, 32'h60C0, 12));
        vecs.push_back(mk(1, 32'h00221820, 1, 0, 0, 32'h0,        0, 0, 32'h0,  0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 32'h8C260000, 0, 0, 0, 32'h0,        0, 0, 32'h0,  0, 1, 1, 1, 32'h22, 32'h66, 0, 6));
        vecs.push_back(mk(1, 32'h00C23820, 1, 0, 0, 32'h0,        0, 0, 32'h0,  0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 32'h00C23820, 0, 0, 0, 32'h0,        0, 0, 32'h0,  0, 1, 1, 0, 32'h66, 32'h7, 32'h3820, 7));
        vecs.push_back(mk(1, 32'h8C260000, 0, 0, 0, 32'h0,        0, 0, 32'h0,  0, 1, 1, 1, 32'h22, 32'h66, 0, 6));
        vecs.push_back(mk(1, 32'h00463820, 0, 0, 0, 32'h0,        0, 0, 32'h0,  1, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 32'h8C200000, 0, 0, 0, 32'h0,        0, 0, 32'h0,  0, 1, 1, 1, 32'h22, 0, 0, 0));
        vecs.push_back(mk(1, 32'h00023820, 0, 0, 0, 32'h0,        0, 0, 32'h0,  0, 1, 1, 0, 0, 32'h7, 32'h3820, 7));
        vecs.push_back(mk(1, 32'h00021820, 0, 1, 0, 32'hFFFFFFFF, 1, 0, 32'h77, 0, 1, 1, 0, 0, 32'h7, 32'h1820, 3));
        vecs.push_back(mk(1, 32'h00221820, 0, 0, 0, 32'h0,        1, 2, 32'h99, 0, 1, 1, 0, 32'h22, 32'h99, 32'h1820, 3));
        vecs.push_back(mk(1, 32'h8C260000, 0, 0, 0, 32'h0,        0, 0, 32'h0,  0, 1, 1, 1, 32'h22, 32'h66, 0, 6));
        vecs.push_back(mk(0, 32'h00C23820, 0, 0, 0, 32'h0,        0, 0, 32'h0,  0, 0, 0, 0, 0, 0, 0, 0));

        drive(mk(0, 32'h0, 0, 0, 0, 32'h0, 0, 0, 32'h0, 0, 0, 0, 0, 0, 0, 0, 0));
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i], $sformatf("v%0d", i));
        end

        // Reset asserted while a load-use stall is pending.
        apply(mk(1, 32'h8C260000, 0, 0, 0, 32'h0, 0, 0, 32'h0, 0, 1, 1, 1, 32'h22, 32'h66, 0, 6), "rs_lw");
        drive(mk(1, 32'h00C23820, 0, 0, 0, 32'h0, 0, 0, 32'h0, 0, 0, 0, 0, 0, 0, 0, 0));
        #1;
        chk("rs_mid.stall", 32'(o_stall), 32'h1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk_all_zero("rs_after");
        rst = 1'b0;
        // Register file must have been cleared by reset.
        apply(mk(1, 32'h00221820, 0, 0, 0, 32'h0, 0, 0, 32'h0, 0, 1, 1, 0, 0, 0, 32'h1820, 3), "rs_rf");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
